// File: rtl/bus_frame_pkg.sv
// Shared definitions for the 10-phase byte-serial CPU bus frame.
// Used by both the pin handler and the target endpoint.
package bus_frame_pkg;

    typedef logic [3:0] frame_ph_t;

    localparam frame_ph_t PH_IDLE = 4'd0;
    localparam frame_ph_t PH_A0   = 4'd1;
    localparam frame_ph_t PH_A1   = 4'd2;
    localparam frame_ph_t PH_A2   = 4'd3;
    localparam frame_ph_t PH_A3   = 4'd4;
    localparam frame_ph_t PH_FLAG = 4'd5;
    localparam frame_ph_t PH_D0   = 4'd6;
    localparam frame_ph_t PH_D1   = 4'd7;
    localparam frame_ph_t PH_D2   = 4'd8;
    localparam frame_ph_t PH_D3   = 4'd9;
    localparam frame_ph_t PH_LAST = 4'd9;

    localparam int unsigned FLAG_WR_BIT = 0;

    // Read data goes out MSB byte first: PH_D0 carries w[31:24].
    function automatic logic [7:0] rd_lane(input logic [31:0] w, input frame_ph_t ph);
        logic [1:0] idx;
        idx = 2'(PH_D3 - ph);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bus_frame_phase_ctr.sv
// Wrapping frame phase counter (0..PH_LAST) with asynchronous active-low reset.
module bus_frame_phase_ctr
    import bus_frame_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    output frame_ph_t ph_o
);

    frame_ph_t ph_q, ph_d;

    always_comb begin
        ph_d = (ph_q == PH_LAST) ? PH_IDLE : ph_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q <= PH_IDLE;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign ph_o = ph_q;

endmodule

// File: rtl/bus_frame_target.sv
// Target endpoint of the byte-serial CPU bus frame, bridging to a 32-bit word memory port.
// Optional error counter output err_cnt is enabled by defining BUS_FRAME_ERRCNT_EN.
module bus_frame_target
    import bus_frame_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF,
    parameter int unsigned WR_WAIT_MAX = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        addr_byte_i,
    input  logic [7:0]        data_byte_i,
    output logic [7:0]        data_byte_o,
    output logic              data_oe,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
`ifdef BUS_FRAME_ERRCNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              err
);

    localparam logic [7:0] WCNT_LAST = 8'(WR_WAIT_MAX - 1);

    frame_ph_t ph;

    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              wr_q, wr_d, err_q, err_d, wr_pend_q, wr_pend_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [1:0]        lane;
    logic              miss_ev, abandon_ev;

    bus_frame_phase_ctr u_phase_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .ph_o (ph)
    );

    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        mwdata_d   = mwdata_q;
        maddr_d    = maddr_q;
        wr_d       = wr_q;
        wr_pend_d  = wr_pend_q;
        wcnt_d     = wcnt_q;
        miss_ev    = 1'b0;
        abandon_ev = 1'b0;
        lane       = 2'(ph - PH_A0);

        // Posted write: hold the request until acked or the wait window runs out.
        if (wr_pend_q) begin
            if (mem_ack) begin
                wr_pend_d = 1'b0;
            end else if (wcnt_q == WCNT_LAST) begin
                wr_pend_d  = 1'b0;
                abandon_ev = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 8'd1;
            end
        end

        case (ph)
            PH_A0, PH_A1, PH_A2, PH_A3: begin
                addr_d[{lane, 3'b000} +: 8]  = addr_byte_i;
                wdata_d[{lane, 3'b000} +: 8] = data_byte_i;
                // Present the complete address to memory from PH_FLAG onwards only.
                if (ph == PH_A3) begin
                    maddr_d = ADDR_W'({addr_byte_i, addr_q[23:0]});
                end
            end
            PH_FLAG: begin
                wr_d   = addr_byte_i[FLAG_WR_BIT];
                rbuf_d = mem_ack ? mem_rdata : ERR_PATTERN;
                if (addr_byte_i[FLAG_WR_BIT]) begin
                    wr_pend_d = 1'b1;
                    wcnt_d    = 8'd0;
                    mwdata_d  = wdata_q;
                end else if (!mem_ack) begin
                    miss_ev = 1'b1;
                end
            end
            default: ;
        endcase

        err_d = err_q | miss_ev | abandon_ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            mwdata_q  <= '0;
            maddr_q   <= '0;
            wr_q      <= 1'b0;
            wr_pend_q <= 1'b0;
            wcnt_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
            mwdata_q  <= mwdata_d;
            maddr_q   <= maddr_d;
            wr_q      <= wr_d;
            wr_pend_q <= wr_pend_d;
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
        end
    end

`ifdef BUS_FRAME_ERRCNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((miss_ev || abandon_ev) && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

    assign mem_req     = (ph == PH_FLAG) | wr_pend_q;
    assign mem_we      = wr_pend_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = mwdata_q;
    assign data_oe     = ~wr_q & (ph >= PH_D0);
    assign data_byte_o = data_oe ? rd_lane(rbuf_q, ph) : 8'h00;
    assign err         = err_q;

endmodule
